alu_dispatch: RTL
=================

ALU_DISPATCH -- requirements
Module: alu_dispatch

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request-queue entries; power of 2, 2..16.
REQ-002 Parameter ALU_LAT, default 2, cycles from the op_start cycle to a valid ALU result; legal range 1..15.
REQ-003 clk  in  1  single clock; all logic on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  upstream request valid.
REQ-006 req_ready  out  1  queue can accept a request.
REQ-007 req_op  in  2  operation code, passed through unmodified.
REQ-008 req_a / req_b  in  8 each  operands.
REQ-009 op_start  out  1  one-cycle ALU start pulse.
REQ-010 operation  out  2  drives the ALU operation input.
REQ-011 operand_a / operand_b  out  8 each  drive the ALU operand inputs.
REQ-012 result  in  16  ALU result.
REQ-013 rsp_valid  out  1  response valid.
REQ-014 rsp_ready  in  1  downstream accepts the response.
REQ-015 rsp_result  out  16  captured ALU result.
REQ-016 rsp_op  out  2  operation code of the response.
REQ-017 busy  out  1  high when the FSM is not IDLE or the queue is non-empty.

Function
REQ-018 The queue SHALL be an in-order FIFO of {op,a,b}; a push occurs on req_valid && req_ready; req_ready = !full.
REQ-019 When full, req_ready SHALL be low even if a pop occurs in the same cycle; there is no bypass path.
REQ-020 A push into an empty FIFO SHALL become poppable on the following cycle, not the same cycle.
REQ-021 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP.
REQ-022 IDLE SHALL move to ISSUE when the FIFO is non-empty and stay in IDLE otherwise.
REQ-023 In ISSUE, op_start=1 for exactly one cycle, operation/operand_a/operand_b SHALL take the FIFO head, the head SHALL be popped, and the next state SHALL be WAIT.
REQ-024 operation/operand_a/operand_b SHALL remain stable from the ISSUE cycle through the last WAIT cycle, and SHALL hold their last values otherwise.
REQ-025 With op_start high in cycle T, result SHALL be sampled at the edge ending cycle T+ALU_LAT into rsp_result, and rsp_op SHALL be set in the same way; the FSM SHALL then enter RESP.
REQ-026 rsp_valid SHALL be high exactly in RESP, first in cycle T+ALU_LAT+1.
REQ-027 While rsp_valid=1 and rsp_ready=0, rsp_result and rsp_op SHALL hold stable.
REQ-028 On rsp_valid && rsp_ready, the FSM SHALL go to ISSUE if the FIFO is non-empty, otherwise to IDLE.
REQ-029 Only one operation SHALL be outstanding at the ALU at any time.
REQ-030 Minimum latency: a request accepted at the edge ending cycle 0 into an idle, empty block SHALL produce op_start in cycle 2.
REQ-031 FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH, with a separate full/empty distinction (extra pointer bit or count).

Reset
REQ-032 While rst=1 at a rising edge, the block SHALL go to FSM=IDLE with the FIFO emptied and pointers at 0.
REQ-033 After that reset edge, op_start=0, rsp_valid=0, operation=0, operand_a=0, operand_b=0, rsp_result=0, rsp_op=0 and busy=0.
REQ-034 req_ready SHALL be 0 during reset and 1 on the first cycle after rst deasserts.
REQ-035 A reset in any state SHALL discard queued requests and any in-flight or pending response; the discarded response SHALL never be presented.

Configuration
REQ-036 Macro ALU_DISPATCH_STATS_EN, when defined, SHALL add output op_count[15:0].
REQ-037 op_count SHALL be reset to 0 and SHALL increment on each rsp_valid && rsp_ready, wrapping from 16'hFFFF to 0.
REQ-038 Without ALU_DISPATCH_STATS_EN, the port and counter SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-039 Single op, ALU_LAT=2: push op=2'b01, a=8'h05, b=8'h03 at cycle 0, model returns 16'h0008 -> op_start in cycle 2 with operand_a=8'h05 and operand_b=8'h03; rsp_valid in cycle 5 with rsp_result=16'h0008 and rsp_op=2'b01.
REQ-040 Fill, FIFO_DEPTH=4: hold rsp_ready=0 and push 6 requests -> 1 in flight + 4 queued, req_ready=0 after the 5th accept; drain -> responses appear in push order.
REQ-041 Backpressure: hold rsp_ready=0 for 10 cycles in RESP -> rsp_result and rsp_op stable, no further op_start.
REQ-042 Back-to-back: two queued requests with rsp_ready=1 -> the second op_start occurs in the cycle immediately after the first response handshake.
REQ-043 Reset mid-WAIT with 3 queued -> next cycle busy=0, rsp_valid=0, req_ready=1, and no response is ever presented for the discarded requests.
REQ-044 STATS: 3 completed handshakes -> op_count=3; force op_count to 16'hFFFF and complete one more -> op_count=0.

Source files
------------

// File: rtl/alu_dispatch.sv
// Request FIFO feeding a single-outstanding ALU issue/wait/response sequencer.
// Define ALU_DISPATCH_STATS_EN to add the op_count completed-handshake counter.
module alu_dispatch #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned ALU_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [7:0]  req_a,
  input  logic [7:0]  req_b,
  output logic        op_start,
  output logic [1:0]  operation,
  output logic [7:0]  operand_a,
  output logic [7:0]  operand_b,
  input  logic [15:0] result,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [1:0]  rsp_op,
`ifdef ALU_DISPATCH_STATS_EN
  output logic [15:0] op_count,
`endif
  output logic        busy
);

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] PTR_ONE = 1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic [17:0] mem [FIFO_DEPTH];
  logic [PW:0] wr_ptr, rd_ptr;
  logic [17:0] head;
  logic [3:0]  wait_cnt;
  logic        empty, full, push, pop;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign req_ready = !rst && !full;
  assign push      = req_valid && req_ready;
  assign pop       = (state == ISSUE);
  assign head      = mem[rd_ptr[PW-1:0]];
  assign busy      = (state != IDLE) || !empty;

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PW-1:0]] <= {req_op, req_a, req_b};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Operands are loaded on the edge entering ISSUE so they are already valid
  // during the op_start cycle; the head entry itself is popped at the end of ISSUE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_start   <= 1'b0;
      operation  <= '0;
      operand_a  <= '0;
      operand_b  <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_op     <= '0;
      wait_cnt   <= '0;
    end else begin
      op_start <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            state <= ISSUE;
            op_start <= 1'b1;
            {operation, operand_a, operand_b} <= head;
          end
        end
        ISSUE: begin
          state    <= WAIT;
          wait_cnt <= 4'(ALU_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            state      <= RESP;
            rsp_valid  <= 1'b1;
            rsp_result <= result;
            rsp_op     <= operation;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            if (!empty) begin
              state <= ISSUE;
              op_start <= 1'b1;
              {operation, operand_a, operand_b} <= head;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ALU_DISPATCH_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) op_count <= '0;
    else if (rsp_valid && rsp_ready) op_count <= op_count + 16'd1;
  end
`endif

endmodule
